// File: rtl/dispatch_queue.sv
// Decoder-to-backend dispatch FIFO: one registered dispatch per cycle, one cycle after the push edge at the earliest.
// A full RS/LSB/RoB stalls the head in place; a full queue deasserts DPDC_ready; a mispredict empties everything.
module dispatch_queue #(
   parameter int ADDR_WIDTH  = 32,
   parameter int REG_WIDTH   = 5,
   parameter int RoB_WIDTH   = 4,
   parameter int DEPTH_WIDTH = 2,
   parameter int CDB_PORTS   = 2
) (
   input  logic                          Sys_clk,
   input  logic                          Sys_rst_n,
   input  logic                          Sys_rdy,
   input  logic                          DCDP_valid,
   output logic                          DPDC_ready,
   input  logic [ADDR_WIDTH-1:0]         DCDP_pc,
   input  logic [6:0]                    DCDP_opcode,
   input  logic [REG_WIDTH-1:0]          DCDP_rs1,
   input  logic [REG_WIDTH-1:0]          DCDP_rs2,
   input  logic [REG_WIDTH-1:0]          DCDP_rd,
   input  logic [31:0]                   DCDP_imm,
   input  logic                          DCDP_predict_result,
   output logic [REG_WIDTH:0]            DPRF_rs1,
   output logic [REG_WIDTH:0]            DPRF_rs2,
   input  logic [RoB_WIDTH:0]            RFDP_Qj,
   input  logic [RoB_WIDTH:0]            RFDP_Qk,
   input  logic [31:0]                   RFDP_Vj,
   input  logic [31:0]                   RFDP_Vk,
   output logic                          DPRF_en,
   output logic [REG_WIDTH:0]            DPRF_rd,
   output logic [RoB_WIDTH-1:0]          DPRF_RoB_index,
   input  logic                          RSDP_full,
   input  logic                          LSBDP_full,
   input  logic                          RoBDP_full,
   output logic                          DPRS_en,
   output logic                          DPLSB_en,
   output logic [ADDR_WIDTH-1:0]         DPEX_pc,
   output logic [6:0]                    DPEX_opcode,
   output logic [31:0]                   DPEX_imm,
   output logic [RoB_WIDTH:0]            DPEX_Qj,
   output logic [RoB_WIDTH:0]            DPEX_Qk,
   output logic [31:0]                   DPEX_Vj,
   output logic [31:0]                   DPEX_Vk,
   output logic [RoB_WIDTH-1:0]          DPEX_RoB_index,
   input  logic [RoB_WIDTH-1:0]          RoBDP_RoB_index,
   input  logic                          RoBDP_pre_judge,
   output logic [RoB_WIDTH:0]            DPRoB_Qj,
   output logic [RoB_WIDTH:0]            DPRoB_Qk,
   input  logic                          RoBDP_Qj_ready,
   input  logic                          RoBDP_Qk_ready,
   input  logic [31:0]                   RoBDP_Vj,
   input  logic [31:0]                   RoBDP_Vk,
   output logic                          DPRoB_en,
   output logic [ADDR_WIDTH-1:0]         DPRoB_pc,
   output logic [6:0]                    DPRoB_opcode,
   output logic                          DPRoB_predict_result,
   output logic [REG_WIDTH:0]            DPRoB_rd,
   input  logic [CDB_PORTS-1:0]          CDB_en,
   input  logic [CDB_PORTS*RoB_WIDTH-1:0] CDB_index,
   input  logic [CDB_PORTS*32-1:0]       CDB_value
);
   localparam int DEPTH = 1 << DEPTH_WIDTH;
   localparam logic [REG_WIDTH:0]     NON_REG = {1'b1, {REG_WIDTH{1'b0}}};
   localparam logic [RoB_WIDTH:0]     NON_DEP = {1'b1, {RoB_WIDTH{1'b0}}};
   localparam logic [DEPTH_WIDTH:0]   CNT_FULL = {1'b1, {DEPTH_WIDTH{1'b0}}};
   localparam logic [DEPTH_WIDTH:0]   CNT_ONE = 1;
   localparam logic [DEPTH_WIDTH-1:0] PTR_ONE = 1;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [6:0]            opcode;
      logic [REG_WIDTH-1:0]  rs1;
      logic [REG_WIDTH-1:0]  rs2;
      logic [REG_WIDTH-1:0]  rd;
      logic [31:0]           imm;
      logic                  predict_result;
   } entry_t;

   entry_t                 mem [DEPTH];
   entry_t                 hd;
   logic [DEPTH_WIDTH-1:0] head, tail;
   logic [DEPTH_WIDTH:0]   count;
   logic                   not_empty, is_ls, push, fire;
   logic [RoB_WIDTH:0]     qj, qk;
   logic [31:0]            vj, vk;

   function automatic logic in_range(input logic [6:0] op, input logic [6:0] lo, input logic [6:0] hi);
      return (op >= lo) && (op <= hi);
   endfunction

   assign hd        = mem[head];
   assign not_empty = (count != '0);
   assign is_ls     = in_range(hd.opcode, 7'd11, 7'd18);
   assign DPDC_ready = (count < CNT_FULL) & RoBDP_pre_judge & Sys_rdy;
   assign push      = DCDP_valid & DPDC_ready;
   assign fire      = Sys_rdy & RoBDP_pre_judge & not_empty & ~RoBDP_full &
                      (is_ls ? ~LSBDP_full : ~RSDP_full);

   assign DPRF_rs1 = (!not_empty || in_range(hd.opcode, 7'd1, 7'd3)) ? NON_REG : {1'b0, hd.rs1};
   assign DPRF_rs2 = (!not_empty || in_range(hd.opcode, 7'd1, 7'd4) || in_range(hd.opcode, 7'd11, 7'd15) ||
                      in_range(hd.opcode, 7'd19, 7'd27)) ? NON_REG : {1'b0, hd.rs2};
   assign DPRoB_Qj = RFDP_Qj;
   assign DPRoB_Qk = RFDP_Qk;

   // RoB result beats CDB; among CDB channels the lowest index wins.
   always_comb begin
      logic hit_j, hit_k;
      qj = RFDP_Qj;
      qk = RFDP_Qk;
      vj = RFDP_Vj;
      vk = RFDP_Vk;
      hit_j = 1'b0;
      hit_k = 1'b0;
      if (RFDP_Qj != NON_DEP && RoBDP_Qj_ready) begin
         qj = NON_DEP;
         vj = RoBDP_Vj;
      end else if (RFDP_Qj != NON_DEP) begin
         for (int i = 0; i < CDB_PORTS; i++) begin
            if (!hit_j && CDB_en[i] && RFDP_Qj == {1'b0, CDB_index[i*RoB_WIDTH +: RoB_WIDTH]}) begin
               hit_j = 1'b1;
               qj = NON_DEP;
               vj = CDB_value[i*32 +: 32];
            end
         end
      end
      if (RFDP_Qk != NON_DEP && RoBDP_Qk_ready) begin
         qk = NON_DEP;
         vk = RoBDP_Vk;
      end else if (RFDP_Qk != NON_DEP) begin
         for (int i = 0; i < CDB_PORTS; i++) begin
            if (!hit_k && CDB_en[i] && RFDP_Qk == {1'b0, CDB_index[i*RoB_WIDTH +: RoB_WIDTH]}) begin
               hit_k = 1'b1;
               qk = NON_DEP;
               vk = CDB_value[i*32 +: 32];
            end
         end
      end
   end

   always_ff @(posedge Sys_clk) begin
      if (push) begin
         mem[tail] <= '{pc: DCDP_pc, opcode: DCDP_opcode, rs1: DCDP_rs1, rs2: DCDP_rs2,
                        rd: DCDP_rd, imm: DCDP_imm, predict_result: DCDP_predict_result};
      end
   end

   always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
      if (!Sys_rst_n) begin
         head <= '0;
         tail <= '0;
         count <= '0;
         DPRF_en <= 1'b0;
         DPRoB_en <= 1'b0;
         DPRS_en <= 1'b0;
         DPLSB_en <= 1'b0;
         DPEX_pc <= '0;
         DPEX_opcode <= '0;
         DPEX_imm <= '0;
         DPEX_Qj <= NON_DEP;
         DPEX_Qk <= NON_DEP;
         DPEX_Vj <= '0;
         DPEX_Vk <= '0;
         DPEX_RoB_index <= '0;
         DPRF_RoB_index <= '0;
         DPRF_rd <= NON_REG;
         DPRoB_rd <= NON_REG;
         DPRoB_pc <= '0;
         DPRoB_opcode <= '0;
         DPRoB_predict_result <= 1'b0;
      end else if (!RoBDP_pre_judge) begin
         head <= '0;
         tail <= '0;
         count <= '0;
         DPRF_en <= 1'b0;
         DPRoB_en <= 1'b0;
         DPRS_en <= 1'b0;
         DPLSB_en <= 1'b0;
      end else begin
         DPRF_en <= fire;
         DPRoB_en <= fire;
         DPRS_en <= fire & ~is_ls;
         DPLSB_en <= fire & is_ls;
         if (fire) begin
            DPEX_pc <= hd.pc;
            DPEX_opcode <= hd.opcode;
            DPEX_imm <= hd.imm;
            DPEX_Qj <= qj;
            DPEX_Qk <= qk;
            DPEX_Vj <= vj;
            DPEX_Vk <= vk;
            DPEX_RoB_index <= RoBDP_RoB_index;
            DPRF_RoB_index <= RoBDP_RoB_index;
            DPRF_rd <= (in_range(hd.opcode, 7'd5, 7'd10) || in_range(hd.opcode, 7'd16, 7'd18)) ?
                       NON_REG : {1'b0, hd.rd};
            DPRoB_rd <= (in_range(hd.opcode, 7'd5, 7'd10) || in_range(hd.opcode, 7'd16, 7'd18)) ?
                        NON_REG : {1'b0, hd.rd};
            DPRoB_pc <= hd.pc;
            DPRoB_opcode <= hd.opcode;
            DPRoB_predict_result <= hd.predict_result;
            head <= head + PTR_ONE;
         end
         if (push) tail <= tail + PTR_ONE;
         if (push && !fire) count <= count + CNT_ONE;
         else if (!push && fire) count <= count - CNT_ONE;
      end
   end
endmodule
